timex_paging_ctrl: RTL
======================

// Module: timex_paging_ctrl
// PURPOSE
//  Clocked, parametrised successor to the Timex FDD paging/decode logic. Samples the Z80 bus on CLK,
//  traps M1 fetches at N configurable addresses to page the interface ROM/RAM in, and pages out on
//  access to a configurable exit address. Generates ZX ROM override, interface ROM/RAM selects and
//  I/O port strobes, and keeps page-in statistics. Sits between the Spectrum edge connector and the
//  interface memory/latches inside the CPLD.
// PARAMETERS
//  TRAP_COUNT    2                      number of page-in trap addresses
//  TRAP_ADDRS    {16'h0008,16'h0000}    packed TRAP_COUNT x 16b trap list, entry 0 in LSBs
//  PAGEOUT_ADDR  16'h0604               page-out address (full 16-bit match)
//  ROM_AW        12                     interface ROM window address width (echoes above)
//  RAM_BASE      16'h2000               RAM window base; ROM window is 0x0000..RAM_BASE-1
//  RAM_AW        11                     interface RAM address width (echoes to 0x3FFF)
//  IO_PORT       8'h3F                  I/O port matched on A[7:0]
//  SYNC_STAGES   2                      synchroniser depth for nMREQ/nM1/nRFSH (>=2)
// PORTS
//  CLK        in   1   system clock, >=4x Z80 clock
//  RST        in   1   synchronous reset, active high
//  A          in   16  Z80 address bus
//  nMREQ      in   1   memory request, active low
//  nIORQ      in   1   I/O request, active low
//  nRD,nWR    in   1   read/write strobes, active low
//  nM1        in   1   opcode fetch, active low
//  nRFSH      in   1   refresh cycle, active low
//  D0,D1      in   1   data bits (used only with SOFT_PAGE_CTRL_EN)
//  nZX_ROMCS  out  1   registered; high while paged in
//  nROM_CS    out  1   comb: ~(paged & ~nMREQ & A<RAM_BASE & A[15:14]==0)
//  nRAM_CS    out  1   comb: ~(paged & ~nMREQ & A in RAM_BASE..0x3FFF)
//  LS273      out  1   comb, high: ~nIORQ & ~nWR & A[7:0]==IO_PORT
//  nLS244     out  1   comb, low:  ~nIORQ & ~nRD & A[7:0]==IO_PORT
//  PAGED      out  1   registered paging state
//  TRAP_HIT   out  TRAP_COUNT  one-hot index of the trap that caused the last page-in
//  PAGEIN_CNT out  8   saturating count of page-in events
// BEHAVIOUR
//  - Reset: state OUT, PAGED=0, nZX_ROMCS=0, TRAP_HIT=0, PAGEIN_CNT=0, pending flags cleared.
//  - nMREQ/nM1/nRFSH pass SYNC_STAGES flops; A sampled in the same cycle as synced nMREQ.
//  - While synced nMREQ=0 and nRFSH=1: set pend_in (and record trap index) if nM1=0 and A matches
//    any TRAP_ADDRS entry; set pend_out if A==PAGEOUT_ADDR (any fetch/read/write). Refresh never triggers.
//  - Cycle end = synced nMREQ 0->1. FSM: OUT -> IN on cycle end with pend_in; IN -> OUT on cycle end
//    with pend_out. Pending flags clear on every cycle end. State/PAGED/nZX_ROMCS update on the CLK
//    edge after the cycle-end edge is detected (takes effect from the next bus cycle).
//  - pend_in and pend_out in same cycle (overlapping parameters): page-in wins.
//  - Trap while already IN: TRAP_HIT updates, PAGEIN_CNT unchanged, stays IN.
//  - Multiple trap entries matching: lowest index reported.
//  - PAGEIN_CNT increments on OUT->IN only; holds at 8'hFF.
//  - RST mid-cycle: immediate OUT; the cycle in flight cannot page in after reset releases.
//  - Chip selects and I/O strobes are combinational on raw bus signals gated by registered PAGED.
// CONFIGURATION
//  SOFT_PAGE_CTRL_EN defined: an I/O write to IO_PORT+1 (synced nIORQ/nWR low, cycle end) loads
//    ctrl: D0=1 forces OUT next CLK; D1=1 inhibits all traps until cleared. Ctrl resets to 0.
//    Force-out and a same-cycle page-in never coincide (I/O vs memory cycle).
//  Undefined: port IO_PORT+1 ignored, D0/D1 unused, traps always enabled.
// TESTING
//  1. RST, then M1 fetch at 0x0000 -> after nMREQ rise +SYNC_STAGES+1 CLK: PAGED=1, nZX_ROMCS=1,
//     TRAP_HIT=2'b01, PAGEIN_CNT=1; memory read 0x0000 without M1 -> no page-in.
//  2. Paged in: read 0x2345 -> nRAM_CS=0, nROM_CS=1; read 0x1FFF -> nROM_CS=0; read 0x4000 -> both 1.
//  3. Paged in, data read at 0x0604 -> PAGED=0 after cycle end; read 0x0605 -> remains paged.
//  4. Refresh cycle with A=0x0008, nM1=0, nRFSH=0 -> no page-in; M1 fetch at 0x0008 -> TRAP_HIT=2'b10.
//  5. 300 page-in/out pairs -> PAGEIN_CNT saturates at 8'hFF; RST asserted mid-M1 at 0x0000 -> PAGED=0,
//     cnt=0 after release.
//  6. OUT to 0x3F -> LS273 high only during nIORQ&nWR; IN 0x3F -> nLS244 low; with SOFT_PAGE_CTRL_EN,
//     OUT 0x40 data 0x02 then fetch 0x0000 -> stays OUT; OUT 0x40 data 0x01 while IN -> PAGED=0.

Source files
------------

// File: rtl/timex_bus_if.sv
// Z80 edge-connector bus and paging-controller outputs as seen inside the CPLD.
// master = bus/CPU side, slave = timex_paging_ctrl.
interface timex_bus_if #(
    parameter int unsigned TRAP_COUNT = 2
);
    logic [15:0]           A;
    logic                  nMREQ;
    logic                  nIORQ;
    logic                  nRD;
    logic                  nWR;
    logic                  nM1;
    logic                  nRFSH;
    logic                  D0;
    logic                  D1;
    logic                  nZX_ROMCS;
    logic                  nROM_CS;
    logic                  nRAM_CS;
    logic                  LS273;
    logic                  nLS244;
    logic                  PAGED;
    logic [TRAP_COUNT-1:0] TRAP_HIT;
    logic [7:0]            PAGEIN_CNT;

    modport master (
        output A, nMREQ, nIORQ, nRD, nWR, nM1, nRFSH, D0, D1,
        input  nZX_ROMCS, nROM_CS, nRAM_CS, LS273, nLS244, PAGED, TRAP_HIT, PAGEIN_CNT
    );

    modport slave (
        input  A, nMREQ, nIORQ, nRD, nWR, nM1, nRFSH, D0, D1,
        output nZX_ROMCS, nROM_CS, nRAM_CS, LS273, nLS244, PAGED, TRAP_HIT, PAGEIN_CNT
    );
endinterface

// File: rtl/timex_paging_ctrl.sv
// Clocked Timex FDD paging controller: M1 trap page-in, exit-address page-out, chip selects.
// Optional feature macro SOFT_PAGE_CTRL_EN adds a control port at IO_PORT+1 (force-out, trap inhibit).
module timex_paging_ctrl #(
    parameter int unsigned              TRAP_COUNT   = 2,
    parameter logic [TRAP_COUNT*16-1:0] TRAP_ADDRS   = {16'h0008, 16'h0000},
    parameter logic [15:0]              PAGEOUT_ADDR = 16'h0604,
    parameter int unsigned              ROM_AW       = 12,
    parameter logic [15:0]              RAM_BASE     = 16'h2000,
    parameter int unsigned              RAM_AW       = 11,
    parameter logic [7:0]               IO_PORT      = 8'h3F,
    parameter int unsigned              SYNC_STAGES  = 2
) (
    input logic        CLK,
    input logic        RST,
    timex_bus_if.slave bus
);

    // Window widths must fit the decoded regions they echo within.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if ((32'd1 << ROM_AW) > 32'(RAM_BASE) || 32'(RAM_BASE) > 32'h4000) begin : g_bad_rom
        $error("ROM window does not fit below RAM_BASE");
    end
    if ((32'd1 << RAM_AW) > (32'h4000 - 32'(RAM_BASE))) begin : g_bad_ram
        $error("RAM window does not fit in RAM_BASE..0x3FFF");
    end

    typedef enum logic {ST_OUT, ST_IN} state_t;

    state_t                  state;
    logic                    paged;
    logic                    zx_romcs_n;
    logic [TRAP_COUNT-1:0]   trap_hit;
    logic [7:0]              pagein_cnt;

    logic [SYNC_STAGES-1:0]  mreq_sync;
    logic [SYNC_STAGES-1:0]  m1_sync;
    logic [SYNC_STAGES-1:0]  rfsh_sync;
    logic                    mreq_d;
    logic                    armed;
    logic                    pend_in;
    logic                    pend_out;
    logic [TRAP_COUNT-1:0]   trap_lat;

    logic                    mreq_s;
    logic                    m1_s;
    logic                    rfsh_s;
    logic                    cycle_end;
    logic                    trap_any;
    logic [TRAP_COUNT-1:0]   trap_onehot;
    logic                    force_out;
    logic                    traps_en;

    assign mreq_s    = mreq_sync[SYNC_STAGES-1];
    assign m1_s      = m1_sync[SYNC_STAGES-1];
    assign rfsh_s    = rfsh_sync[SYNC_STAGES-1];
    assign cycle_end = mreq_s & ~mreq_d;

    // Lowest matching trap index wins.
    always_comb begin
        trap_onehot = '0;
        trap_any    = 1'b0;
        for (int unsigned i = 0; i < TRAP_COUNT; i++) begin
            if (!trap_any && bus.A == TRAP_ADDRS[i*16 +: 16]) begin
                trap_onehot[i] = 1'b1;
                trap_any       = 1'b1;
            end
        end
    end

    // Sync chains reset low and armed stays clear until a synced nMREQ high is seen,
    // so a bus cycle already in flight at reset release cannot page in.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_OUT;
            paged      <= 1'b0;
            zx_romcs_n <= 1'b0;
            trap_hit   <= '0;
            pagein_cnt <= '0;
            mreq_sync  <= '0;
            m1_sync    <= '0;
            rfsh_sync  <= '0;
            mreq_d     <= 1'b0;
            armed      <= 1'b0;
            pend_in    <= 1'b0;
            pend_out   <= 1'b0;
            trap_lat   <= '0;
        end else begin
            mreq_sync <= {mreq_sync[SYNC_STAGES-2:0], bus.nMREQ};
            m1_sync   <= {m1_sync[SYNC_STAGES-2:0], bus.nM1};
            rfsh_sync <= {rfsh_sync[SYNC_STAGES-2:0], bus.nRFSH};
            mreq_d    <= mreq_s;
            if (mreq_s) begin
                armed <= 1'b1;
            end

            if (force_out) begin
                state      <= ST_OUT;
                paged      <= 1'b0;
                zx_romcs_n <= 1'b0;
            end else if (cycle_end) begin
                pend_in  <= 1'b0;
                pend_out <= 1'b0;
                if (pend_in) begin
                    state      <= ST_IN;
                    paged      <= 1'b1;
                    zx_romcs_n <= 1'b1;
                    trap_hit   <= trap_lat;
                    if (state == ST_OUT && pagein_cnt != 8'hFF) begin
                        pagein_cnt <= pagein_cnt + 8'd1;
                    end
                end else if (pend_out && state == ST_IN) begin
                    state      <= ST_OUT;
                    paged      <= 1'b0;
                    zx_romcs_n <= 1'b0;
                end
            end else if (!mreq_s && rfsh_s && armed) begin
                if (!m1_s && trap_any && traps_en) begin
                    pend_in  <= 1'b1;
                    trap_lat <= trap_onehot;
                end
                if (bus.A == PAGEOUT_ADDR) begin
                    pend_out <= 1'b1;
                end
            end
        end
    end

`ifdef SOFT_PAGE_CTRL_EN
    logic [SYNC_STAGES-1:0] iorq_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic                   iorq_d;
    logic                   pend_ctrl;
    logic [1:0]             ctrl_data;
    logic                   inhibit;
    logic                   io_end;

    assign io_end = iorq_sync[SYNC_STAGES-1] & ~iorq_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            iorq_sync <= '1;
            wr_sync   <= '1;
            iorq_d    <= 1'b1;
            pend_ctrl <= 1'b0;
            ctrl_data <= '0;
            inhibit   <= 1'b0;
        end else begin
            iorq_sync <= {iorq_sync[SYNC_STAGES-2:0], bus.nIORQ};
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], bus.nWR};
            iorq_d    <= iorq_sync[SYNC_STAGES-1];
            if (io_end) begin
                pend_ctrl <= 1'b0;
                if (pend_ctrl) begin
                    inhibit <= ctrl_data[1];
                end
            end else if (!iorq_sync[SYNC_STAGES-1] && !wr_sync[SYNC_STAGES-1] &&
                         bus.A[7:0] == IO_PORT + 8'd1) begin
                pend_ctrl <= 1'b1;
                ctrl_data <= {bus.D1, bus.D0};
            end
        end
    end

    assign force_out = io_end & pend_ctrl & ctrl_data[0];
    assign traps_en  = ~inhibit;
`else
    logic unused_data;
    assign unused_data = &{1'b0, bus.D0, bus.D1};
    assign force_out   = 1'b0;
    assign traps_en    = 1'b1;
`endif

    logic rom_win;
    logic ram_win;
    logic port_hit;

    assign rom_win  = (bus.A < RAM_BASE) && (bus.A[15:14] == 2'b00);
    assign ram_win  = (bus.A >= RAM_BASE) && (bus.A <= 16'h3FFF);
    assign port_hit = (bus.A[7:0] == IO_PORT);

    assign bus.nROM_CS    = ~(paged & ~bus.nMREQ & rom_win);
    assign bus.nRAM_CS    = ~(paged & ~bus.nMREQ & ram_win);
    assign bus.LS273      = ~bus.nIORQ & ~bus.nWR & port_hit;
    assign bus.nLS244     = ~(~bus.nIORQ & ~bus.nRD & port_hit);
    assign bus.nZX_ROMCS  = zx_romcs_n;
    assign bus.PAGED      = paged;
    assign bus.TRAP_HIT   = trap_hit;
    assign bus.PAGEIN_CNT = pagein_cnt;

endmodule
